// File: rtl/uart_alu_sequencer.sv
// Frame controller: pops A, B and opcode bytes from the RX FIFO, drives the ALU and pushes
// the latched result into the TX FIFO. An inter-byte timeout drops partial frames.
module uart_alu_sequencer #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned NB_TIMEOUT     = 21
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_empty,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic               o_rd_uart,
    input  logic               i_tx_full,
    output logic               o_wr_uart,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_busy,
    output logic               o_frame_error
);

    typedef enum logic [2:0] {StA, StB, StOp, StExec, StSend} state_e;

    localparam bit                    TimeoutEn   = (TIMEOUT_CYCLES != 0);
    localparam logic [NB_TIMEOUT-1:0] TimeoutLast = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [NB_DATA-1:0]    data_a_q, data_a_d;
    logic [NB_DATA-1:0]    data_b_q, data_b_d;
    logic [NB_OP-1:0]      alu_op_q, alu_op_d;
    logic [NB_DATA-1:0]    tx_data_q, tx_data_d;
    logic [NB_TIMEOUT-1:0] tmo_q, tmo_d;
    logic                  rd_en, wr_en, frame_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StA;
            data_a_q  <= '0;
            data_b_q  <= '0;
            alu_op_q  <= '0;
            tx_data_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        tmo_d     = tmo_q;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        frame_err = 1'b0;

        unique case (state_q)
            StA: begin
                tmo_d = '0;
                if (!i_rx_empty) begin
                    rd_en    = 1'b1;
                    data_a_d = i_rx_data;
                    state_d  = StB;
                end
            end
            StB, StOp: begin
                if (!i_rx_empty) begin
                    // An available byte always wins over a timeout expiring this cycle.
                    rd_en = 1'b1;
                    tmo_d = '0;
                    if (state_q == StB) begin
                        data_b_d = i_rx_data;
                        state_d  = StOp;
                    end else begin
                        alu_op_d = i_rx_data[NB_OP-1:0];
                        state_d  = StExec;
                    end
                end else if (TimeoutEn) begin
                    if (tmo_q == TimeoutLast) begin
                        frame_err = 1'b1;
                        tmo_d     = '0;
                        state_d   = StA;
                    end else begin
                        tmo_d = tmo_q + NB_TIMEOUT'(1);
                    end
                end
            end
            StExec: begin
                tx_data_d = i_alu_result;
                state_d   = StSend;
            end
            StSend: begin
                if (!i_tx_full) begin
                    wr_en   = 1'b1;
                    state_d = StA;
                end
            end
            default: state_d = StA;
        endcase

        // No FIFO traffic or error pulses while reset is asserted.
        if (i_reset) begin
            rd_en     = 1'b0;
            wr_en     = 1'b0;
            frame_err = 1'b0;
        end
    end

    assign o_rd_uart     = rd_en;
    assign o_wr_uart     = wr_en;
    assign o_frame_error = frame_err;
    assign o_tx_data     = tx_data_q;
    assign o_data_a      = data_a_q;
    assign o_data_b      = data_b_q;
    assign o_alu_op      = alu_op_q;
    assign o_busy        = (state_q != StA);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Scoreboard bench: queue-based RX/TX FIFO models, a stub ALU and a frame-level result model.
module tb_uart_alu_sequencer;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TMO     = 16;

    logic               clk = 1'b0;
    logic               i_reset, i_rx_empty, i_tx_full;
    logic [NB_DATA-1:0] i_rx_data, i_alu_result;
    logic               o_rd_uart, o_wr_uart, o_busy, o_frame_error;
    logic [NB_DATA-1:0] o_tx_data, o_data_a, o_data_b;
    logic [NB_OP-1:0]   o_alu_op;

    uart_alu_sequencer #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CYCLES(TMO), .NB_TIMEOUT(5)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_rx_empty(i_rx_empty), .i_rx_data(i_rx_data),
        .o_rd_uart(o_rd_uart), .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart),
        .o_tx_data(o_tx_data), .o_data_a(o_data_a), .o_data_b(o_data_b),
        .o_alu_op(o_alu_op), .i_alu_result(i_alu_result), .o_busy(o_busy),
        .o_frame_error(o_frame_error)
    );

    always #5 clk = ~clk;

    // Environment ALU stub
    always_comb begin
        case (o_alu_op)
            6'h20:   i_alu_result = o_data_a + o_data_b;
            6'h22:   i_alu_result = o_data_a - o_data_b;
            default: i_alu_result = o_data_a ^ o_data_b;
        endcase
    end

    int tests = 0, fails = 0, cyc = 0, err_total = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int rd_log[$], wr_log[$], err_log[$];
    bit pop_pending = 0, force_full = 0, rand_full = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: result of one complete frame, from the opcode rules.
    function automatic logic [7:0] ref_result(input logic [7:0] a, b, ob);
        int op = int'(ob) % 64;
        if (op == 32) return 8'((int'(a) + int'(b)) % 256);
        if (op == 34) return 8'((int'(a) - int'(b) + 256) % 256);
        return a ^ b;
    endfunction

    // Monitor: sample outputs mid-cycle, compare pushes against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        pop_pending = o_rd_uart;
        check("rd_wr_overlap", 32'(o_rd_uart & o_wr_uart), 0);
        check("pop_when_empty", 32'(o_rd_uart & i_rx_empty), 0);
        if (o_rd_uart) rd_log.push_back(cyc);
        if (o_frame_error) begin
            err_log.push_back(cyc);
            err_total++;
        end
        if (o_wr_uart) begin
            wr_log.push_back(cyc);
            check("push_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("tx_data", 32'(o_tx_data), 32'(exp_q.pop_front()));
        end
    end

    // RX FIFO model (show-ahead) and TX full driver.
    always @(posedge clk) begin
        #1;
        if (pop_pending && rx_q.size() != 0) rx_q.delete(0);
        i_tx_full = force_full || (rand_full && ($urandom_range(0, 2) == 0));
        #1;
        i_rx_empty = (rx_q.size() == 0);
        i_rx_data  = i_rx_empty ? 8'h00 : rx_q[0];
    end

    task automatic push_byte(input logic [7:0] v);
        @(posedge clk);
        #1;
        rx_q.push_back(v);
    endtask

    task automatic push3(input logic [7:0] a, b, ob);
        @(posedge clk);
        #1;
        rx_q.push_back(a);
        rx_q.push_back(b);
        rx_q.push_back(ob);
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        err_log.delete();
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(exp_q.size() == 0 && rx_q.size() == 0 && !o_busy) && k < 2000);
        check("idle_reached", 32'(k < 2000), 1);
    endtask

    task automatic wait_rd(input int n);
        int k = 0;
        while (rd_log.size() < n && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("pops_seen", 32'(rd_log.size() >= n), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        int a0, drop_cyc;
        logic [7:0] ra, rb, rop;
        i_reset = 1'b1; i_rx_empty = 1'b1; i_rx_data = '0; i_tx_full = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outs", {o_data_a, o_data_b, o_alu_op, o_tx_data,
                             o_rd_uart, o_wr_uart, o_busy, o_frame_error}, 0);
        @(posedge clk);
        #1 i_reset = 1'b0;

        // 1: single frame, consecutive pops, push two cycles after the OP pop
        clear_logs();
        exp_q.push_back(ref_result(8'h05, 8'h03, 8'h20));
        push3(8'h05, 8'h03, 8'h20);
        wait_idle();
        check("t1_pops", rd_log.size(), 3);
        check("t1_pushes", wr_log.size(), 1);
        if (rd_log.size() == 3 && wr_log.size() == 1) begin
            check("t1_pop_b_cycle", rd_log[1], rd_log[0] + 1);
            check("t1_pop_op_cycle", rd_log[2], rd_log[0] + 2);
            check("t1_push_latency", wr_log[0], rd_log[2] + 2);
        end
        check("t1_data_a", o_data_a, 8'h05);
        check("t1_data_b", o_data_b, 8'h03);
        check("t1_alu_op", o_alu_op, 6'h20);

        // 2: TX full holds the result until it drops
        clear_logs();
        force_full = 1;
        exp_q.push_back(ref_result(8'hFF, 8'h02, 8'h20));
        push3(8'hFF, 8'h02, 8'h20);
        repeat (14) @(negedge clk);
        #1;
        check("t2_no_push", wr_log.size(), 0);
        check("t2_tx_hold", o_tx_data, 8'h01);
        check("t2_busy", o_busy, 1);
        @(posedge clk);
        force_full = 0;
        drop_cyc = cyc + 1;
        wait_idle();
        check("t2_pushes", wr_log.size(), 1);
        if (wr_log.size() == 1) check("t2_push_cycle", wr_log[0], drop_cyc);

        // 3: two preloaded frames back to back
        clear_logs();
        exp_q.push_back(ref_result(8'h05, 8'h03, 8'h20));
        exp_q.push_back(ref_result(8'h09, 8'h04, 8'h22));
        @(posedge clk);
        #1;
        rx_q = '{8'h05, 8'h03, 8'h20, 8'h09, 8'h04, 8'h22};
        wait_idle();
        check("t3_pops", rd_log.size(), 6);
        check("t3_pushes", wr_log.size(), 2);
        if (rd_log.size() == 6 && wr_log.size() == 2)
            check("t3_back_to_back", rd_log[3], wr_log[0] + 1);

        // 4: lone byte times out, then a fresh frame works
        clear_logs();
        push_byte(8'h07);
        wait_rd(1);
        repeat (20) @(negedge clk);
        #1;
        check("t4_errors", err_log.size(), 1);
        if (err_log.size() == 1 && rd_log.size() == 1)
            check("t4_error_cycle", err_log[0], rd_log[0] + TMO);
        check("t4_idle", o_busy, 0);
        check("t4_no_push", wr_log.size(), 0);
        exp_q.push_back(ref_result(8'h01, 8'h01, 8'h20));
        push3(8'h01, 8'h01, 8'h20);
        wait_idle();
        check("t4_push", wr_log.size(), 1);

        // 5: byte B arrives exactly on the expiry cycle
        clear_logs();
        push_byte(8'h10);
        wait_rd(1);
        a0 = (rd_log.size() > 0) ? rd_log[0] : cyc;
        for (int k = 0; k < 40 && cyc < a0 + TMO - 1; k++) begin
            @(posedge clk);
            #1;
        end
        exp_q.push_back(ref_result(8'h10, 8'h20, 8'h22));
        rx_q.push_back(8'h20);
        rx_q.push_back(8'h22);
        wait_idle();
        check("t5_pops", rd_log.size(), 3);
        if (rd_log.size() == 3) check("t5_b_cycle", rd_log[1], a0 + TMO);
        check("t5_errors", err_log.size(), 0);
        check("t5_pushes", wr_log.size(), 1);

        // 6: reset mid-frame clears everything
        clear_logs();
        push3(8'h11, 8'h22, 8'h00);
        rx_q.delete(2);
        wait_rd(2);
        @(posedge clk);
        #1 i_reset = 1'b1;
        @(posedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);
        #1;
        check("t6_reset_outs", {o_data_a, o_data_b, o_alu_op, o_tx_data,
                                o_rd_uart, o_wr_uart, o_busy, o_frame_error}, 0);
        exp_q.push_back(ref_result(8'h02, 8'h03, 8'h20));
        push3(8'h02, 8'h03, 8'h20);
        wait_idle();
        check("t6_pushes", wr_log.size(), 1);
        check("t6_errors", err_log.size(), 0);

        // Randomized frames with inter-byte gaps below the timeout and random TX back-pressure
        clear_logs();
        rand_full = 1;
        for (int f = 0; f < 40; f++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = {2'($urandom), ($urandom_range(0, 3) == 0) ? 6'($urandom) :
                   (($urandom_range(0, 1) == 1) ? 6'h20 : 6'h22)};
            exp_q.push_back(ref_result(ra, rb, rop));
            push_byte(ra);
            repeat ($urandom_range(0, 10)) @(posedge clk);
            push_byte(rb);
            repeat ($urandom_range(0, 10)) @(posedge clk);
            push_byte(rop);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        rand_full = 0;
        wait_idle();
        check("rand_pushes", wr_log.size(), 40);
        check("rand_pops", rd_log.size(), 120);
        check("total_errors", err_total, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
